// File: rtl/random_ca_multichannel_if.sv
// Control and output handshake bundle for the multichannel CA random source.
// The master side (consumer/controller) drives stepping, seeding, the rule
// table and out_ready; the slave side (the generator) returns the word stream.
interface random_ca_multichannel_if #(
  parameter int Width = 32
);
  logic             ce;
  logic [Width-1:0] seed;
  logic             seed_load;
  logic             rule_wr;
  logic [1:0]       rule_addr;
  logic [7:0]       rule_data;
  logic [Width-1:0] Q;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       recover_count;

  modport master (
    output ce, seed, seed_load, rule_wr, rule_addr, rule_data, out_ready,
    input  Q, out_valid, recover_count
  );

  modport slave (
    input  ce, seed, seed_load, rule_wr, rule_addr, rule_data, out_ready,
    output Q, out_valid, recover_count
  );
endinterface

// File: rtl/random_ca_multichannel.sv
// Pseudo-random word source built from Channels independent 1-D elementary
// cellular automata (cyclic rings of Width cells). Each channel picks its rule
// from a 4-entry runtime-writable table, offset by channel index and rotated
// every RulePeriod steps. Dead rings (all-0/all-1) are reseeded from the last
// seed. A warm-up phase discards the first WarmupSteps words after a seed
// load, and the output is a valid/ready stream whose backpressure freezes
// the automata.
module random_ca_multichannel #(
  parameter int Width       = 32,
  parameter int Channels    = 4,
  parameter int RulePeriod  = 64,
  parameter int WarmupSteps = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  random_ca_multichannel_if.slave bus
);

  localparam int StepW = $clog2(RulePeriod);
  localparam int WarmW = $clog2(WarmupSteps + 2);
  localparam logic [WarmW-1:0] WarmLast = WarmW'((WarmupSteps > 0) ? WarmupSteps - 1 : 0);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t             state_reg, state_next;
  logic [7:0]         rule_reg [4];
  logic [Width-1:0]   seed_reg;
  logic [Width-1:0]   q_reg;
  logic               out_valid_reg;
  logic [7:0]         recover_count_reg;
  logic [1:0]         epoch_reg;
  logic [StepW-1:0]   step_cnt_reg;
  logic [WarmW-1:0]   warm_cnt_reg;
  logic               step;
  logic [Width-1:0]   nxt_all [Channels];
  logic [Channels-1:0] recover_vec;
  logic [Width-1:0]   mix;

  // Force bit0 high and the MSB low so a ring can never start all-0 or all-1.
  function automatic logic [Width-1:0] fix_state(input logic [Width-1:0] v);
    logic [Width-1:0] r;
    r           = v;
    r[0]        = 1'b1;
    r[Width-1]  = 1'b0;
    return r;
  endfunction

  // Rotate left by n (n < Width) via a doubled word, avoiding oversize shifts.
  function automatic logic [Width-1:0] rotl(input logic [Width-1:0] v, input int unsigned n);
    logic [2*Width-1:0] d;
    d = {v, v} << n;
    return d[2*Width-1:Width];
  endfunction

  // A step advances every channel; a pending unaccepted word blocks it in RUN.
  assign step = bus.ce && (state_reg != IDLE) && !bus.seed_load &&
                ((state_reg == WARMUP) || !out_valid_reg || bus.out_ready);

  assign bus.Q             = q_reg;
  assign bus.out_valid     = out_valid_reg;
  assign bus.recover_count = recover_count_reg;

  for (genvar gi = 0; gi < Channels; gi++) begin : g_ch
    localparam int          Rot = (3 * gi) % Width;
    localparam logic [1:0]  Off = 2'(gi % 4);
    logic [Width-1:0] ch_reg;
    logic [Width-1:0] raw;
    logic [Width-1:0] nxt;
    logic [1:0]       rule_idx;
    logic [7:0]       rule;
    logic             dead;

    assign rule_idx = epoch_reg + Off;
    assign rule     = rule_reg[rule_idx];

    for (genvar gj = 0; gj < Width; gj++) begin : g_cell
      assign raw[gj] = rule[{ch_reg[(gj + 1) % Width], ch_reg[gj], ch_reg[(gj + Width - 1) % Width]}];
    end

    assign dead            = (raw == '0) || (raw == '1);
    assign nxt             = dead ? fix_state(rotl(seed_reg, Rot)) : raw;
    assign nxt_all[gi]     = nxt;
    assign recover_vec[gi] = dead;

    // Channel ring: seeded from a rotated seed, otherwise advanced on each step.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ch_reg <= '0;
      end else if (bus.seed_load) begin
        ch_reg <= fix_state(rotl(bus.seed, Rot));
      end else if (step) begin
        ch_reg <= nxt;
      end
    end
  end

  // Fold all post-recovery channel states into one word.
  always_comb begin
    mix = '0;
    for (int k = 0; k < Channels; k++) begin
      mix = mix ^ nxt_all[k];
    end
  end

  // Rule table: reset defaults, runtime writes land after any same-cycle step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rule_reg[0] <= 8'd30;
      rule_reg[1] <= 8'd90;
      rule_reg[2] <= 8'd150;
      rule_reg[3] <= 8'd110;
    end else if (bus.rule_wr) begin
      rule_reg[bus.rule_addr] <= bus.rule_data;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state: seeding restarts from any state; warm-up ends after its last step.
  always_comb begin
    state_next = state_reg;
    if (bus.seed_load) begin
      state_next = (WarmupSteps == 0) ? RUN : WARMUP;
    end else if (step && (state_reg == WARMUP) && (warm_cnt_reg == WarmLast)) begin
      state_next = RUN;
    end
  end

  // Warm-up step counter, cleared by each seed load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt_reg <= '0;
    end else if (bus.seed_load) begin
      warm_cnt_reg <= '0;
    end else if (step && (state_reg == WARMUP)) begin
      warm_cnt_reg <= warm_cnt_reg + WarmW'(1);
    end
  end

  // Output word, handshake, epoch tracking and the recovery counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_reg          <= '0;
      q_reg             <= '0;
      out_valid_reg     <= 1'b0;
      recover_count_reg <= '0;
      epoch_reg         <= '0;
      step_cnt_reg      <= '0;
    end else if (bus.seed_load) begin
      seed_reg      <= bus.seed;
      q_reg         <= '0;
      out_valid_reg <= 1'b0;
      epoch_reg     <= '0;
      step_cnt_reg  <= '0;
    end else if (step) begin
      q_reg        <= {q_reg[Width-2:0], q_reg[Width-1]} ^ mix;
      step_cnt_reg <= step_cnt_reg + StepW'(1);
      if (step_cnt_reg == '1) begin
        epoch_reg <= epoch_reg + 2'd1;
      end
      if (state_reg == RUN) begin
        out_valid_reg <= 1'b1;
      end
      if ((|recover_vec) && (recover_count_reg != 8'hFF)) begin
        recover_count_reg <= recover_count_reg + 8'd1;
      end
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_random_ca_multichannel.sv
// Self-checking bench for random_ca_multichannel. A behavioural model predicts
// every accepted word; accepted words are queued at stimulus time and checked
// by a monitor thread. A second small instance gets known-answer checks.
module tb_random_ca_multichannel;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int RP = 4;
  localparam int WU = 3;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_RUN  = 2;

  typedef struct {
    logic [W-1:0] q;
    logic [7:0]   rc;
  } exp_t;

  logic clk;
  logic rst;

  random_ca_multichannel_if #(.Width(W)) m_if ();
  random_ca_multichannel_if #(.Width(8)) d_if ();

  random_ca_multichannel #(.Width(W), .Channels(C), .RulePeriod(RP), .WarmupSteps(WU)) dut (
    .clk(clk), .rst(rst), .bus(m_if)
  );

  random_ca_multichannel #(.Width(8), .Channels(1), .RulePeriod(64), .WarmupSteps(0)) dut1 (
    .clk(clk), .rst(rst), .bus(d_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_words = 0;
  exp_t exp_q[$];

  // Behavioural model state
  logic [W-1:0] m_ch [C];
  int           m_tab [4];
  logic [W-1:0] m_seed;
  logic [W-1:0] m_q;
  logic         m_valid;
  int           m_rc, m_epoch, m_steps, m_warm, m_state;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic logic [W-1:0] rotl_m(input logic [W-1:0] v, input int n);
    int s;
    s = n % W;
    return (v << s) | (v >> (W - s));
  endfunction

  function automatic logic [W-1:0] fix_m(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    r[0] = 1'b1;
    r[W-1] = 1'b0;
    return r;
  endfunction

  function automatic logic [W-1:0] ca_next(input int rule, input logic [W-1:0] s);
    logic [W-1:0] n;
    int idx;
    for (int i = 0; i < W; i++) begin
      idx  = 4 * int'(s[(i + 1) % W]) + 2 * int'(s[i]) + int'(s[(i + W - 1) % W]);
      n[i] = 1'((rule >> idx) & 1);
    end
    return n;
  endfunction

  task automatic model_reset();
    m_tab[0] = 30; m_tab[1] = 90; m_tab[2] = 150; m_tab[3] = 110;
    for (int k = 0; k < C; k++) m_ch[k] = '0;
    m_seed = '0; m_q = '0; m_valid = 1'b0;
    m_rc = 0; m_epoch = 0; m_steps = 0; m_warm = 0; m_state = M_IDLE;
  endtask

  // Advance the model across one clock edge using the inputs now on m_if.
  task automatic model_edge();
    logic [W-1:0] acc, nx;
    bit any, stp;
    if (m_valid && m_if.out_ready) exp_q.push_back('{m_q, 8'(m_rc)});
    if (m_if.seed_load) begin
      m_seed = m_if.seed;
      for (int k = 0; k < C; k++) m_ch[k] = fix_m(rotl_m(m_if.seed, 3 * k));
      m_q = '0; m_valid = 1'b0; m_epoch = 0; m_steps = 0; m_warm = 0;
      m_state = (WU == 0) ? M_RUN : M_WARM;
    end else begin
      stp = m_if.ce && (m_state != M_IDLE) && (m_state == M_WARM || !m_valid || m_if.out_ready);
      if (stp) begin
        acc = '0; any = 0;
        for (int k = 0; k < C; k++) begin
          nx = ca_next(m_tab[(m_epoch + k) % 4], m_ch[k]);
          if (nx == '0 || nx == '1) begin
            nx  = fix_m(rotl_m(m_seed, 3 * k));
            any = 1;
          end
          m_ch[k] = nx;
          acc ^= nx;
        end
        m_q = rotl_m(m_q, 1) ^ acc;
        if (any && m_rc < 255) m_rc++;
        m_steps++;
        if (m_steps == RP) begin
          m_steps = 0;
          m_epoch = (m_epoch + 1) % 4;
        end
        if (m_state == M_RUN) begin
          m_valid = 1'b1;
        end else begin
          m_warm++;
          if (m_warm == WU) m_state = M_RUN;
        end
      end else if (m_valid && m_if.out_ready) begin
        m_valid = 1'b0;
      end
    end
    if (m_if.rule_wr) m_tab[m_if.rule_addr] = int'(m_if.rule_data);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("valid", 32'(m_if.out_valid), 32'(m_valid));
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_if.out_valid && m_if.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL word_unexpected: got Q=%h rc=%0d, required no word", m_if.Q, m_if.recover_count);
        end else begin
          e = exp_q.pop_front();
          if (m_if.Q !== e.q || m_if.recover_count !== e.rc) begin
            n_err++;
            $display("FAIL word%0d: got Q=%h rc=%0d, required Q=%h rc=%0d",
                     n_words, m_if.Q, m_if.recover_count, e.q, e.rc);
          end else begin
            $display("word %0d: Q=%h rc=%0d", n_words, m_if.Q, m_if.recover_count);
          end
        end
        n_words++;
      end
    end
  endtask

  task automatic idle_inputs();
    m_if.ce = 0; m_if.seed_load = 0; m_if.rule_wr = 0; m_if.out_ready = 0;
    m_if.rule_addr = 0; m_if.rule_data = 0;
    d_if.ce = 0; d_if.seed_load = 0; d_if.rule_wr = 0; d_if.out_ready = 0;
    d_if.rule_addr = 0; d_if.rule_data = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q"}, 32'(m_if.Q), 32'h0);
    check({tag, "_valid"}, 32'(m_if.out_valid), 32'h0);
    check({tag, "_rc"}, 32'(m_if.recover_count), 32'h0);
    check({tag, "_d1_rc"}, 32'(d_if.recover_count), 32'h0);
  endtask

  // Asynchronous reset asserted away from the clock edge, then released.
  task automatic do_reset(input string tag);
    idle_inputs();
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic seed_main(input logic [W-1:0] s, input logic ce_v);
    m_if.seed = s; m_if.seed_load = 1; m_if.ce = ce_v; m_if.out_ready = 1;
    tick();
    m_if.seed_load = 0;
  endtask

  task automatic run_main(input int n, input logic rdy);
    m_if.ce = 1; m_if.out_ready = rdy;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic random_run(input int n, input int ld_pct, input int wr_pct);
    for (int i = 0; i < n; i++) begin
      m_if.ce        = ($urandom_range(99) < 75);
      m_if.out_ready = ($urandom_range(99) < 70);
      m_if.seed_load = ($urandom_range(99) < ld_pct);
      m_if.seed      = W'($urandom);
      m_if.rule_wr   = ($urandom_range(99) < wr_pct);
      m_if.rule_addr = 2'($urandom);
      m_if.rule_data = 8'($urandom);
      tick();
    end
    m_if.seed_load = 0; m_if.rule_wr = 0;
  endtask

  initial begin
    rst = 1'b0;
    m_if.seed = '0; d_if.seed = '0;
    idle_inputs();
    model_reset();
    fork
      monitor();
    join_none

    // Power-up reset
    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // IDLE must emit nothing even with ce and out_ready high
    run_main(8, 1);
    idle_inputs();

    // Known-answer sequence on the single-channel instance
    d_if.seed = 8'h01; d_if.seed_load = 1;
    tick();
    d_if.seed_load = 0; d_if.ce = 1; d_if.out_ready = 1;
    check("d1_valid_after_load", 32'(d_if.out_valid), 32'h0);
    tick();
    check("d1_q1", 32'(d_if.Q), 32'h83);
    check("d1_valid1", 32'(d_if.out_valid), 32'h1);
    tick();
    check("d1_q2", 32'(d_if.Q), 32'h41);
    d_if.ce = 0;
    tick();
    check("d1_valid_drop", 32'(d_if.out_valid), 32'h0);
    check("d1_q_hold", 32'(d_if.Q), 32'h41);

    // Rule 0 everywhere: every step recovers to 8'h01, counter saturates
    for (int a = 0; a < 4; a++) begin
      d_if.rule_wr = 1; d_if.rule_addr = 2'(a); d_if.rule_data = 8'h00;
      tick();
    end
    d_if.rule_wr = 0;
    d_if.seed = 8'h01; d_if.seed_load = 1;
    tick();
    d_if.seed_load = 0; d_if.ce = 1; d_if.out_ready = 1;
    tick();
    check("d1_rec_q1", 32'(d_if.Q), 32'h01);
    check("d1_rec_rc1", 32'(d_if.recover_count), 32'd1);
    tick();
    check("d1_rec_q2", 32'(d_if.Q), 32'h03);
    check("d1_rec_rc2", 32'(d_if.recover_count), 32'd2);
    tick();
    check("d1_rec_q3", 32'(d_if.Q), 32'h07);
    check("d1_rec_rc3", 32'(d_if.recover_count), 32'd3);
    for (int i = 0; i < 260; i++) tick();
    check("d1_rc_sat", 32'(d_if.recover_count), 32'd255);
    d_if.ce = 0; d_if.out_ready = 0;

    // Main: warm-up then run, followed by a 5-cycle stall
    seed_main(8'hA5, 1);
    run_main(12, 1);
    for (int i = 0; i < 5; i++) begin
      run_main(1, 0);
      check("stall_q", 32'(m_if.Q), 32'(m_q));
    end
    run_main(12, 1);

    // Randomised traffic with occasional reseeds and rule writes
    random_run(400, 2, 5);

    // Reset mid-run, IDLE afterwards, reseed restarts the sequence
    seed_main(8'h3C, 1);
    run_main(8, 1);
    do_reset("midrun");
    run_main(5, 1);
    seed_main(8'h3C, 1);
    run_main(20, 1);

    // Seed load with ce low clears the output
    seed_main(8'h77, 0);
    check("load_ce0_q", 32'(m_if.Q), 32'h0);
    check("load_ce0_valid", 32'(m_if.out_valid), 32'h0);

    // Dead rules on all entries: recovery counter saturates on the main instance
    m_if.ce = 0;
    for (int a = 0; a < 4; a++) begin
      m_if.rule_wr = 1; m_if.rule_addr = 2'(a); m_if.rule_data = 8'h00;
      tick();
    end
    m_if.rule_wr = 0;
    seed_main(8'h5A, 1);
    run_main(300, 1);
    check("main_rc_sat", 32'(m_if.recover_count), 32'd255);

    // Restore rules through random writes and more random traffic
    do_reset("final");
    seed_main(8'hC3, 1);
    random_run(300, 1, 3);

    // Drain and confirm every predicted word was seen
    m_if.ce = 0; m_if.seed_load = 0; m_if.out_ready = 1;
    tick();
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
